// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C burst sequencer.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDevW,
        StReg,
        StDataW,
        StDevR,
        StDataR,
        StFin
    } seq_state_e;

    localparam logic I2C_DIR_W = 1'b0;
    localparam logic I2C_DIR_R = 1'b1;

    // Address byte as it appears on the wire: 7-bit address followed by R/W bit.
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic dir);
        return {dev, dir};
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with full/empty flags and a single-cycle flush.
// Push while full and pop while empty are ignored; rdata reads 0 when empty.
module i2c_byte_fifo #(
    parameter int unsigned DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = empty ? 8'h00 : mem[rptr_q[AW-1:0]];
    end

    // Pointer update; flush discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2c_burst_sequencer.sv
// Command-level front end for the I2C byte engine: expands one host command into the
// ordered slot stream (addr+W, reg, data... or addr+W, reg, restart addr+R, read data).
// Optional feature macro: I2C_SEQ_TIMEOUT_EN enables the engine-response watchdog.
module i2c_burst_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned TOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd,
    input  logic [6:0]       cmd_dev,
    input  logic [7:0]       cmd_reg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             tx_wr,
    input  logic [7:0]       tx_wdata,
    output logic             tx_full,
    input  logic             rx_rd,
    output logic [7:0]       rx_rdata,
    output logic             rx_empty,
    output logic             eng_req,
    output logic [7:0]       eng_byte,
    output logic             eng_rd,
    output logic             eng_restart,
    output logic             eng_last,
    input  logic             eng_ack,
    input  logic             eng_nack,
    input  logic [7:0]       eng_rx_byte,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic             rd_q, rd_d;
    logic             err_q, err_d;

    logic       tx_pop, tx_flush, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full;
    logic       slot_active, abort, ack, timeout;

    i2c_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (tx_flush),
        .push  (tx_wr),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    i2c_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (rx_push),
        .wdata (eng_rx_byte),
        .pop   (rx_rd),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TOUT_CYC + 1);
    logic [TW-1:0] tout_q;

    // Watchdog: counts consecutive cycles of an outstanding, unanswered request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    tout_q <= '0;
        else if (eng_req && !eng_ack && !eng_nack)  tout_q <= tout_q + 1'b1;
        else                                        tout_q <= '0;
    end

    assign timeout = eng_req && !eng_ack && !eng_nack && (tout_q == TW'(TOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Engine-facing outputs decoded from state only, so reset clears them asynchronously.
    always_comb begin
        eng_req     = 1'b0;
        eng_byte    = 8'h00;
        eng_rd      = 1'b0;
        eng_restart = 1'b0;
        eng_last    = 1'b0;
        unique case (state_q)
            StDevW: begin
                eng_req  = 1'b1;
                eng_byte = addr_byte(dev_q, I2C_DIR_W);
            end
            StReg: begin
                eng_req  = 1'b1;
                eng_byte = reg_q;
                eng_last = (cnt_q == '0);
            end
            StDevR: begin
                eng_req     = 1'b1;
                eng_byte    = addr_byte(dev_q, I2C_DIR_R);
                eng_restart = 1'b1;
            end
            StDataW: begin
                eng_req  = !tx_empty;
                eng_byte = tx_head;
                eng_last = (cnt_q == LEN_W'(1));
            end
            StDataR: begin
                eng_req  = !rx_full;
                eng_rd   = 1'b1;
                eng_last = (cnt_q == LEN_W'(1));
            end
            default: ;
        endcase
    end

    // Status outputs.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = err_q;
    end

    // Next-state logic; nack (or timeout) takes priority over ack in any slot state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        rd_d     = rd_q;
        err_d    = err_q;
        tx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_push  = 1'b0;

        slot_active = (state_q == StDevW) || (state_q == StReg) || (state_q == StDevR) ||
                      (state_q == StDataW) || (state_q == StDataR);
        abort = slot_active && (eng_nack || timeout);
        ack   = eng_req && eng_ack && !eng_nack;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    dev_d = cmd_dev;
                    reg_d = cmd_reg;
                    rd_d  = cmd_rd;
                    cnt_d = cmd_len;
                    err_d = 1'b0;
                    if (cmd_len > LEN_MAX) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StDevW;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: begin
                if (abort) begin
                    state_d  = StFin;
                    err_d    = 1'b1;
                    tx_flush = 1'b1;
                end else if (ack) begin
                    case (state_q)
                        StDevW: state_d = StReg;
                        StReg: begin
                            if (cnt_q == '0) state_d = StFin;
                            else if (rd_q)   state_d = StDevR;
                            else             state_d = StDataW;
                        end
                        StDevR: state_d = StDataR;
                        StDataW: begin
                            tx_pop = 1'b1;
                            cnt_d  = cnt_q - 1'b1;
                            if (cnt_q == LEN_W'(1)) state_d = StFin;
                        end
                        StDataR: begin
                            rx_push = 1'b1;
                            cnt_d   = cnt_q - 1'b1;
                            if (cnt_q == LEN_W'(1)) state_d = StFin;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Self-checking bench for i2c_burst_sequencer; define I2C_SEQ_TIMEOUT_EN to add the watchdog test.
module tb_i2c_burst_sequencer;
    localparam int DEPTH    = 32;
    localparam int LEN_W    = 6;
    localparam int TOUT_CYC = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_rd = 1'b0;
    logic [6:0]       cmd_dev = '0;
    logic [7:0]       cmd_reg = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             tx_wr = 1'b0;
    logic [7:0]       tx_wdata = '0;
    logic             tx_full;
    logic             rx_rd = 1'b0;
    logic [7:0]       rx_rdata;
    logic             rx_empty;
    logic             eng_req;
    logic [7:0]       eng_byte;
    logic             eng_rd;
    logic             eng_restart;
    logic             eng_last;
    logic             eng_ack = 1'b0;
    logic             eng_nack = 1'b0;
    logic [7:0]       eng_rx_byte = '0;
    logic             busy;
    logic             done;
    logic             err;

    i2c_burst_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TOUT_CYC(TOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rd      (cmd_rd),
        .cmd_dev     (cmd_dev),
        .cmd_reg     (cmd_reg),
        .cmd_len     (cmd_len),
        .tx_wr       (tx_wr),
        .tx_wdata    (tx_wdata),
        .tx_full     (tx_full),
        .rx_rd       (rx_rd),
        .rx_rdata    (rx_rdata),
        .rx_empty    (rx_empty),
        .eng_req     (eng_req),
        .eng_byte    (eng_byte),
        .eng_rd      (eng_rd),
        .eng_restart (eng_restart),
        .eng_last    (eng_last),
        .eng_ack     (eng_ack),
        .eng_nack    (eng_nack),
        .eng_rx_byte (eng_rx_byte),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       rd;
        logic       rs;
        logic       last;
    } slot_t;

    slot_t      exp_q[$];
    logic [7:0] rx_src_q[$];
    logic [7:0] rx_exp_q[$];
    int checks = 0;
    int errors = 0;

    // {cmd_ready, eng_req, eng_byte, eng_rd, eng_restart, eng_last, busy, done, err,
    //  tx_full, rx_empty, rx_rdata}
    localparam logic [25:0] RST_VEC = {1'b1, 1'b0, 8'h00, 7'b0, 1'b1, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_wr    = 1'b1;
        tx_wdata = d;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic exp_slot(input logic [7:0] b, input logic rd, input logic rs, input logic last);
        slot_t s;
        s.b = b; s.rd = rd; s.rs = rs; s.last = last;
        exp_q.push_back(s);
    endtask

    task automatic issue(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [LEN_W-1:0] len);
        cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_len = len; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_before_accept got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Engine model: wait for a request, check it against the scoreboard, hold, then respond.
    task automatic engine_slot(input logic nack);
        slot_t       e;
        int          w = 0;
        logic [10:0] got, want, snap;
        while (eng_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (eng_req !== 1'b1) begin
            errors++;
            $display("FAIL slot_req_timeout got eng_req=%b want 1", eng_req);
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot_unexpected got byte=%h want no request", eng_byte);
            return;
        end
        e    = exp_q.pop_front();
        got  = {(e.rd ? 8'h00 : eng_byte), eng_rd, eng_restart, eng_last};
        want = {(e.rd ? 8'h00 : e.b), e.rd, e.rs, e.last};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL slot_content got %h/rd%b/rs%b/last%b want %h/rd%b/rs%b/last%b",
                     got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
        end
        snap = {eng_byte, eng_rd, eng_restart, eng_last};
        tick();
        checks++;
        if (eng_req !== 1'b1 || {eng_byte, eng_rd, eng_restart, eng_last} !== snap) begin
            errors++;
            $display("FAIL slot_hold got req=%b %h want req=1 %h", eng_req,
                     {eng_byte, eng_rd, eng_restart, eng_last}, snap);
        end
        eng_ack = 1'b1;
        if (nack) eng_nack = 1'b1;
        if (e.rd && rx_src_q.size() > 0) begin
            eng_rx_byte = rx_src_q.pop_front();
            if (!nack) rx_exp_q.push_back(eng_rx_byte);
        end
        tick();
        eng_ack = 1'b0; eng_nack = 1'b0; eng_rx_byte = 8'h00;
    endtask

    task automatic wait_done(input logic exp_err);
        int w = 0;
        while (done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got %b want 1", done);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_at_done got %b want %b", err, exp_err);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle got ready=%b busy=%b done=%b want 1/0/0",
                     cmd_ready, busy, done);
        end
    endtask

    task automatic drain_rx();
        logic [7:0] e;
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || rx_rdata !== e) begin
                errors++;
                $display("FAIL rx_data got empty=%b data=%h want 0/%h", rx_empty, rx_rdata, e);
            end
            rx_rd = 1'b1;
            tick();
            rx_rd = 1'b0;
        end
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL rx_empty_after_drain got %b want 1", rx_empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_ready, eng_req, eng_byte, eng_rd, eng_restart, eng_last, busy, done, err,
             tx_full, rx_empty, rx_rdata} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_state got %h want %h", {cmd_ready, eng_req, eng_byte, eng_rd,
                     eng_restart, eng_last, busy, done, err, tx_full, rx_empty, rx_rdata}, RST_VEC);
        end
    endtask

    task automatic test_write();
        push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h10, 0, 0, 0);
        exp_slot(8'hA1, 0, 0, 0); exp_slot(8'hA2, 0, 0, 0); exp_slot(8'hA3, 0, 0, 1);
        issue(1'b0, 7'h50, 8'h10, 6'd3);
        checks++;
        if (eng_req !== 1'b1) begin
            errors++;
            $display("FAIL req_latency got %b want 1", eng_req);
        end
        for (int i = 0; i < 5; i++) engine_slot(1'b0);
        wait_done(1'b0);
    endtask

    task automatic test_read();
        rx_src_q.push_back(8'h11); rx_src_q.push_back(8'h22);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h00, 0, 0, 0); exp_slot(8'hA1, 0, 1, 0);
        exp_slot(8'h00, 1, 0, 0); exp_slot(8'h00, 1, 0, 1);
        issue(1'b1, 7'h50, 8'h00, 6'd2);
        for (int i = 0; i < 5; i++) engine_slot(1'b0);
        wait_done(1'b0);
        drain_rx();
    endtask

    task automatic test_stall();
        push_tx(8'h77);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h20, 0, 0, 0); exp_slot(8'h77, 0, 0, 0);
        issue(1'b0, 7'h50, 8'h20, 6'd2);
        for (int i = 0; i < 3; i++) engine_slot(1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (eng_req !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL tx_stall got req=%b busy=%b want 0/1", eng_req, busy);
            end
            tick();
        end
        push_tx(8'h55);
        exp_slot(8'h55, 0, 0, 1);
        engine_slot(1'b0);
        wait_done(1'b0);
    endtask

    task automatic test_nack();
        push_tx(8'hB1); push_tx(8'hB2);
        exp_slot(8'hA0, 0, 0, 0);
        issue(1'b0, 7'h50, 8'h30, 6'd2);
        engine_slot(1'b1);
        wait_done(1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h31, 0, 0, 0);
        issue(1'b0, 7'h50, 8'h31, 6'd1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_accept got %b want 0", err);
        end
        for (int i = 0; i < 2; i++) engine_slot(1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (eng_req !== 1'b0) begin
                errors++;
                $display("FAIL tx_flushed got req=%b byte=%h want req=0", eng_req, eng_byte);
            end
            tick();
        end
        push_tx(8'h99);
        exp_slot(8'h99, 0, 0, 1);
        engine_slot(1'b0);
        wait_done(1'b0);
    endtask

    task automatic test_len_bounds();
        issue(1'b0, 7'h50, 8'h40, 6'd33);
        checks++;
        if (eng_req !== 1'b0 || done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL len_overflow got req=%b done=%b err=%b want 0/1/1", eng_req, done, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_overflow_end got done=%b ready=%b want 0/1", done, cmd_ready);
        end
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h10, 0, 0, 1);
        issue(1'b0, 7'h50, 8'h10, 6'd0);
        for (int i = 0; i < 2; i++) engine_slot(1'b0);
        wait_done(1'b0);
    endtask

    task automatic test_full_burst();
        for (int i = 0; i < DEPTH; i++) push_tx(8'(8'h40 + i));
        checks++;
        if (tx_full !== 1'b1) begin
            errors++;
            $display("FAIL tx_full_set got %b want 1", tx_full);
        end
        push_tx(8'hEE);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h55, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) exp_slot(8'(8'h40 + i), 0, 0, (i == DEPTH - 1));
        issue(1'b0, 7'h50, 8'h55, 6'd32);
        for (int i = 0; i < DEPTH + 2; i++) engine_slot(1'b0);
        wait_done(1'b0);
        checks++;
        if (tx_full !== 1'b0) begin
            errors++;
            $display("FAIL tx_full_clear got %b want 0", tx_full);
        end
    endtask

    task automatic test_rst_mid();
        push_tx(8'hC1); push_tx(8'hC2); push_tx(8'hC3);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h60, 0, 0, 0); exp_slot(8'hC1, 0, 0, 0);
        issue(1'b0, 7'h50, 8'h60, 6'd3);
        for (int i = 0; i < 3; i++) engine_slot(1'b0);
        checks++;
        if (eng_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_req got %b want 1", eng_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, eng_req, eng_byte, eng_rd, eng_restart, eng_last, busy, done, err,
             tx_full, rx_empty, rx_rdata} !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset got %h want %h", {cmd_ready, eng_req, eng_byte, eng_rd,
                     eng_restart, eng_last, busy, done, err, tx_full, rx_empty, rx_rdata}, RST_VEC);
        end
        rst = 1'b0;
        tick();
        push_tx(8'h5A);
        exp_slot(8'hA0, 0, 0, 0); exp_slot(8'h61, 0, 0, 0); exp_slot(8'h5A, 0, 0, 1);
        issue(1'b0, 7'h50, 8'h61, 6'd1);
        for (int i = 0; i < 3; i++) engine_slot(1'b0);
        wait_done(1'b0);
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int w = 0;
        issue(1'b1, 7'h50, 8'h70, 6'd1);
        while (done !== 1'b1 && w < TOUT_CYC + 50) begin
            tick();
            w++;
        end
        checks++;
        if (done !== 1'b1 || w != TOUT_CYC || err !== 1'b1) begin
            errors++;
            $display("FAIL watchdog got done=%b after %0d err=%b want 1 after %0d err=1",
                     done, w, err, TOUT_CYC);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_nack();
        test_len_bounds();
        test_full_burst();
        test_rst_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
